alu_req_arbiter: RTL

- Shares one combinational 4-bit ALU (a, b, 3-bit select; out plus carry/overflow/parity/zero/sign flags) between two requesters.
- Arbitrates round-robin and drives the ALU operand and select inputs from registers.
- Holds those inputs stable for a settle window, captures the result and flags, and returns them on a single response channel tagged with the requester ID.
- Intercepts divide-by-zero without issuing the operation to the ALU.

---
 rtl/alu_req_arbiter_if.sv | 61 ++++++
 rtl/alu_req_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// Bundle of the requester, ALU and response signals shared by the arbiter and
// its environment. slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_req_arbiter_if #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned OP_W   = 3
);
  // Requester 0
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  // Requester 1
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  // Shared ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_select;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_overflow;
  logic              alu_parity;
  logic              alu_zero;
  logic              alu_sign;
  // Response channel
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_data;
  logic [4:0]        rsp_flags;
  logic              rsp_err;
  logic              busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    output req0_ready,
    input  req1_valid, req1_op, req1_a, req1_b,
    output req1_ready,
    output alu_a, alu_b, alu_select,
    input  alu_out, alu_carry, alu_overflow, alu_parity, alu_zero, alu_sign,
    output rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    input  req0_ready,
    output req1_valid, req1_op, req1_a, req1_b,
    input  req1_ready,
    input  alu_a, alu_b, alu_select,
    output alu_out, alu_carry, alu_overflow, alu_parity, alu_zero, alu_sign,
    input  rsp_valid, rsp_id, rsp_data, rsp_flags, rsp_err,
    output rsp_ready,
    input  busy
  );
endinterface

// File: rtl/alu_req_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// Operands/select are registered toward the ALU, held for ALU_LAT cycles, then
// the result and flags are captured and returned tagged with the owner ID.
// Divide-by-zero is answered with an error response without touching the ALU.
module alu_req_arbiter #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned OP_W    = 3,
  parameter int unsigned ALU_LAT = 1
) (
  input logic             clk,
  input logic             rst_n,
  alu_req_arbiter_if.slave io_bus
);

  localparam int unsigned     CntW  = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [OP_W-1:0] OpDiv = OP_W'(3);
  localparam logic [CntW-1:0] CntInit = CntW'(ALU_LAT - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e            r_state,     w_state_d;
  logic              r_rr_ptr,    w_rr_ptr_d;
  logic [CntW-1:0]   r_cnt,       w_cnt_d;
  logic [DATA_W-1:0] r_alu_a,     w_alu_a_d;
  logic [DATA_W-1:0] r_alu_b,     w_alu_b_d;
  logic [OP_W-1:0]   r_alu_sel,   w_alu_sel_d;
  logic              r_rsp_id,    w_rsp_id_d;
  logic [DATA_W-1:0] r_rsp_data,  w_rsp_data_d;
  logic [4:0]        r_rsp_flags, w_rsp_flags_d;
  logic              r_rsp_err,   w_rsp_err_d;

  logic              w_idle;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_xfer;
  logic [OP_W-1:0]   w_sel_op;
  logic [DATA_W-1:0] w_sel_a;
  logic [DATA_W-1:0] w_sel_b;
  logic              w_div0;

  assign w_idle = (r_state == StIdle);

  // Lone requester always wins; on contention rr_ptr picks the winner.
  assign w_gnt0 = io_bus.req0_valid & (~io_bus.req1_valid | ~r_rr_ptr);
  assign w_gnt1 = io_bus.req1_valid & (~io_bus.req0_valid |  r_rr_ptr);
  assign w_xfer = w_idle & (w_gnt0 | w_gnt1);

  assign w_sel_op = w_gnt1 ? io_bus.req1_op : io_bus.req0_op;
  assign w_sel_a  = w_gnt1 ? io_bus.req1_a  : io_bus.req0_a;
  assign w_sel_b  = w_gnt1 ? io_bus.req1_b  : io_bus.req0_b;
  assign w_div0   = (w_sel_op == OpDiv) && (w_sel_b == '0);

  assign io_bus.req0_ready = w_gnt0 & w_idle;
  assign io_bus.req1_ready = w_gnt1 & w_idle;
  assign io_bus.alu_a      = r_alu_a;
  assign io_bus.alu_b      = r_alu_b;
  assign io_bus.alu_select = r_alu_sel;
  assign io_bus.rsp_valid  = (r_state == StResp);
  assign io_bus.rsp_id     = r_rsp_id;
  assign io_bus.rsp_data   = r_rsp_data;
  assign io_bus.rsp_flags  = r_rsp_flags;
  assign io_bus.rsp_err    = r_rsp_err;
  assign io_bus.busy       = ~w_idle;

  // Next-state and datapath update for accept, ALU settle and response handshake.
  always_comb begin
    w_state_d     = r_state;
    w_rr_ptr_d    = r_rr_ptr;
    w_cnt_d       = r_cnt;
    w_alu_a_d     = r_alu_a;
    w_alu_b_d     = r_alu_b;
    w_alu_sel_d   = r_alu_sel;
    w_rsp_id_d    = r_rsp_id;
    w_rsp_data_d  = r_rsp_data;
    w_rsp_flags_d = r_rsp_flags;
    w_rsp_err_d   = r_rsp_err;

    unique case (r_state)
      StIdle: begin
        if (w_xfer) begin
          w_rsp_id_d = w_gnt1;
          if (w_div0) begin
            // ALU inputs deliberately left at their previous values.
            w_rsp_err_d   = 1'b1;
            w_rsp_data_d  = '0;
            w_rsp_flags_d = '0;
            w_state_d     = StResp;
          end else begin
            w_alu_a_d   = w_sel_a;
            w_alu_b_d   = w_sel_b;
            w_alu_sel_d = w_sel_op;
            w_cnt_d     = CntInit;
            w_state_d   = StExec;
          end
        end
      end
      StExec: begin
        if (r_cnt == '0) begin
          w_rsp_data_d  = io_bus.alu_out;
          w_rsp_flags_d = {io_bus.alu_carry, io_bus.alu_overflow, io_bus.alu_parity,
                           io_bus.alu_zero, io_bus.alu_sign};
          w_rsp_err_d   = 1'b0;
          w_state_d     = StResp;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      StResp: begin
        if (io_bus.rsp_ready) begin
          w_rr_ptr_d = ~r_rsp_id;
          w_state_d  = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_rr_ptr    <= 1'b0;
      r_cnt       <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_sel   <= '0;
      r_rsp_id    <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_flags <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_cnt       <= w_cnt_d;
      r_alu_a     <= w_alu_a_d;
      r_alu_b     <= w_alu_b_d;
      r_alu_sel   <= w_alu_sel_d;
      r_rsp_id    <= w_rsp_id_d;
      r_rsp_data  <= w_rsp_data_d;
      r_rsp_flags <= w_rsp_flags_d;
      r_rsp_err   <= w_rsp_err_d;
    end
  end

endmodule
